// File: rtl/zx_mem_pkg.sv
// Shared constants and elaboration helpers for the paged ZX memory blocks.
package zx_mem_pkg;

  localparam int PAGE_LOCK_BIT = 5;
  localparam int PAGE_REG_W    = 8;
  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_page_reg.sv
// Paging register with a sticky lock bit; once locked only reset reopens it.
module mem_page_reg
  import zx_mem_pkg::*;
#(
  parameter int PW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  page_wr,
  input  logic [PAGE_REG_W-1:0] page_din,
  output logic [PW-1:0]         page_sel,
  output logic                  page_locked
);

  logic [PW-1:0] page_sel_reg;
  logic          page_locked_reg;
  logic          unused_page_bits;

  // Bits above the page field (other than the lock bit) carry no meaning here.
  assign unused_page_bits = ^page_din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_sel_reg    <= '0;
      page_locked_reg <= 1'b0;
    end else if (page_wr && !page_locked_reg) begin
      page_sel_reg    <= page_din[PW-1:0];
      page_locked_reg <= page_din[PAGE_LOCK_BIT];
    end
  end

  assign page_sel    = page_sel_reg;
  assign page_locked = page_locked_reg;

endmodule

// File: rtl/paged_ram_reg.sv
// Banked synchronous memory addressed as {page_sel, ad}, with a 1- or 2-stage
// read pipeline, a dout_valid strobe and an optional write-protected ROM mode.
module paged_ram_reg
  import zx_mem_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    PAGE_AW   = 14,
  parameter int    NUM_PAGES = 8,
  parameter int    RD_LAT    = 1,
  parameter bit    ROM_MODE  = 1'b0,
  parameter string INIT_FILE = "",
  localparam int   PW        = clog2(NUM_PAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [PAGE_AW-1:0]    ad,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  page_wr,
  input  logic [PAGE_REG_W-1:0] page_din,
  output logic [PW-1:0]         page_sel,
  output logic                  page_locked,
  output logic                  wr_err
);

  localparam int AW    = PW + PAGE_AW;
  localparam int DEPTH = 1 << AW;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("paged_ram_reg: RD_LAT must be 1 or 2");
  end

  if ((1 << PW) != NUM_PAGES) begin : g_bad_pages
    $error("paged_ram_reg: NUM_PAGES must be a power of two");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     eff_addr;
  logic              rd_en;
  logic              wr_en;
  logic              wr_err_reg;

  mem_page_reg #(
    .PW (PW)
  ) u_page_reg (
    .clk         (clk),
    .reset       (reset),
    .page_wr     (page_wr),
    .page_din    (page_din),
    .page_sel    (page_sel),
    .page_locked (page_locked)
  );

  // page_sel is the registered value, so a same-edge page_wr cannot retarget
  // this access; ad never carries into the page field.
  assign eff_addr = {page_sel, ad};
  assign wr_en    = ce && wre;
  assign rd_en    = ce && oce && !wre;

  always_ff @(posedge clk) begin
    if (wr_en && !ROM_MODE) begin
      mem[eff_addr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= ROM_MODE && wr_en;
    end
  end

  // Data stages only load on a valid slot, so dout holds between reads.
  logic [DATA_W-1:0] data_pipe  [RD_LAT];
  logic              valid_pipe [RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pipe[0] <= 1'b0;
      data_pipe[0]  <= '0;
    end else begin
      valid_pipe[0] <= rd_en;
      if (rd_en) begin
        data_pipe[0] <= mem[eff_addr];
      end
    end
  end

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_pipe[gi] <= 1'b0;
        data_pipe[gi]  <= '0;
      end else begin
        valid_pipe[gi] <= valid_pipe[gi-1];
        if (valid_pipe[gi-1]) begin
          data_pipe[gi] <= data_pipe[gi-1];
        end
      end
    end
  end

  assign dout       = data_pipe[RD_LAT-1];
  assign dout_valid = valid_pipe[RD_LAT-1];
  assign wr_err     = wr_err_reg;

endmodule

// File: tb/tb_paged_ram_reg.sv
// Three instances (RAM lat 1, RAM lat 2, ROM lat 1) share one stimulus stream
// and are checked every cycle against an associative-array memory model.
module tb_paged_ram_reg;

  localparam int PAGE_WORDS = 1 << 14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0, oce = 1'b0, wre = 1'b0, page_wr = 1'b0;
  logic [13:0] ad = '0;
  logic [7:0]  din = '0, page_din = '0;

  logic [7:0]  dout1, dout2, dout_r;
  logic        dv1, dv2, dv_r, err1, err2, err_r, lk1, lk2, lk_r;
  logic [2:0]  ps1, ps2, ps_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  paged_ram_reg #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout1), .dout_valid(dv1), .page_wr(page_wr), .page_din(page_din),
    .page_sel(ps1), .page_locked(lk1), .wr_err(err1)
  );

  paged_ram_reg #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout2), .dout_valid(dv2), .page_wr(page_wr), .page_din(page_din),
    .page_sel(ps2), .page_locked(lk2), .wr_err(err2)
  );

  paged_ram_reg #(.RD_LAT(1), .ROM_MODE(1'b1)) u_rom (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .dout(dout_r), .dout_valid(dv_r), .page_wr(page_wr), .page_din(page_din),
    .page_sel(ps_r), .page_locked(lk_r), .wr_err(err_r)
  );

  // Reference model: memory contents, paging state and expected outputs.
  logic [7:0] ram_m [int];
  logic [7:0] rom_m [int];
  int         m_page = 0;
  bit         m_lock = 1'b0;
  bit         e1_v, e2_v, er_v, p_v, er_err;
  bit         e1_k, e2_k, er_k, p_k;
  logic [7:0] e1_d, e2_d, er_d, p_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("d1_valid", 32'(dv1), 32'(e1_v));
    if (e1_k) check("d1_dout", 32'(dout1), 32'(e1_d));
    check("d2_valid", 32'(dv2), 32'(e2_v));
    if (e2_k) check("d2_dout", 32'(dout2), 32'(e2_d));
    check("rom_valid", 32'(dv_r), 32'(er_v));
    if (er_k) check("rom_dout", 32'(dout_r), 32'(er_d));
    check("d1_wr_err", 32'(err1), 32'd0);
    check("d2_wr_err", 32'(err2), 32'd0);
    check("rom_wr_err", 32'(err_r), 32'(er_err));
    check("d1_page_sel", 32'(ps1), 32'(m_page));
    check("d2_page_sel", 32'(ps2), 32'(m_page));
    check("rom_page_sel", 32'(ps_r), 32'(m_page));
    check("d1_locked", 32'(lk1), 32'(m_lock));
    check("d2_locked", 32'(lk2), 32'(m_lock));
    check("rom_locked", 32'(lk_r), 32'(m_lock));
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then check.
  task automatic cycle();
    int eff;
    bit rd, wr;
    eff = m_page * PAGE_WORDS + int'(ad);
    wr  = ce && wre;
    rd  = ce && oce && !wre;
    @(posedge clk);
    e2_v = p_v;
    if (p_v) begin
      e2_d = p_d;
      e2_k = p_k;
    end
    e1_v = rd;
    er_v = rd;
    p_v  = rd;
    if (rd) begin
      e1_k = ram_m.exists(eff);
      e1_d = e1_k ? ram_m[eff] : 8'h00;
      p_k  = e1_k;
      p_d  = e1_d;
      er_k = rom_m.exists(eff);
      er_d = er_k ? rom_m[eff] : 8'h00;
    end
    er_err = wr;
    if (wr) ram_m[eff] = din;
    if (page_wr && !m_lock) begin
      m_page = int'(page_din & 8'h07);
      m_lock = page_din[5];
    end
    #1;
    check_all();
  endtask

  task automatic op(input bit c, input bit o, input bit w, input int a,
                    input logic [7:0] d, input bit pw, input logic [7:0] pd);
    ce = c; oce = o; wre = w; ad = a[13:0]; din = d; page_wr = pw; page_din = pd;
    cycle();
  endtask

  task automatic do_reset();
    ce = 1'b0; oce = 1'b0; wre = 1'b0; page_wr = 1'b0;
    reset = 1'b1;
    #1;
    e1_v = 1'b0; e2_v = 1'b0; er_v = 1'b0; p_v = 1'b0; er_err = 1'b0;
    e1_d = 8'h00; e2_d = 8'h00; er_d = 8'h00;
    e1_k = 1'b1; e2_k = 1'b1; er_k = 1'b1;
    m_page = 0; m_lock = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int idx, a;
    // ROM contents are placed directly into the array; ad 0 of page 0 is 0xF3.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 5; i++) begin
        a = (i == 4) ? 16 : i;
        idx = p * PAGE_WORDS + a;
        rom_m[idx] = (idx == 0) ? 8'hF3 : 8'($urandom);
        u_rom.mem[idx] = rom_m[idx];
      end
    end
    #2;
    do_reset();

    // Prefill the RAM locations the test touches.
    for (int p = 0; p < 8; p++) begin
      op(0, 0, 0, 0, 8'h00, 1, 8'(p));
      for (int i = 0; i < 5; i++) begin
        op(1, 0, 1, (i == 4) ? 16 : i, 8'($urandom), 0, 8'h00);
      end
    end

    // Write then immediate read, lat 1 and lat 2.
    op(0, 0, 0, 0, 8'h00, 1, 8'h00);
    op(1, 0, 1, 16, 8'hA5, 0, 8'h00);
    op(1, 1, 0, 16, 8'h00, 0, 8'h00);
    check("a5_dout", 32'(dout1), 32'h0A5);
    check("a5_valid", 32'(dv1), 32'd1);
    op(0, 0, 0, 0, 8'h00, 0, 8'h00);
    check("a5_pulse_end", 32'(dv1), 32'd0);
    check("a5_lat2", 32'(dout2), 32'h0A5);

    // Page isolation.
    op(0, 0, 0, 0, 8'h00, 1, 8'h03);
    op(1, 0, 1, 0, 8'h11, 0, 8'h00);
    op(0, 0, 0, 0, 8'h00, 1, 8'h04);
    op(1, 0, 1, 0, 8'h22, 0, 8'h00);
    op(0, 0, 0, 0, 8'h00, 1, 8'h03);
    op(1, 1, 0, 0, 8'h00, 0, 8'h00);
    check("iso_p3", 32'(dout1), 32'h11);
    op(0, 0, 0, 0, 8'h00, 1, 8'h04);
    op(1, 1, 0, 0, 8'h00, 0, 8'h00);
    check("iso_p4", 32'(dout1), 32'h22);

    // ROM write is refused and flagged for one cycle.
    op(0, 0, 0, 0, 8'h00, 1, 8'h00);
    op(1, 0, 1, 0, 8'h00, 0, 8'h00);
    check("rom_err_pulse", 32'(err_r), 32'd1);
    op(0, 0, 0, 0, 8'h00, 0, 8'h00);
    check("rom_err_end", 32'(err_r), 32'd0);
    op(1, 1, 0, 0, 8'h00, 0, 8'h00);
    check("rom_keeps", 32'(dout_r), 32'hF3);
    check("ram_written", 32'(dout1), 32'h00);

    // Back-to-back reads through the 2-stage pipeline.
    for (int i = 0; i < 4; i++) op(1, 0, 1, i, 8'(i + 1), 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) op(1, 1, 0, i, 8'h00, 0, 8'h00);
      else       op(0, 0, 0, 0, 8'h00, 0, 8'h00);
      if (i >= 1 && i <= 4) begin
        check("stream_valid", 32'(dv2), 32'd1);
        check("stream_dout", 32'(dout2), 32'(i));
      end else begin
        check("stream_idle", 32'(dv2), 32'd0);
      end
    end

    // page_wr alongside a read: the read still uses the old page.
    op(0, 0, 0, 0, 8'h00, 1, 8'h01);
    op(1, 1, 0, 0, 8'h00, 1, 8'h02);
    check("old_page_rd", 32'(dout1), 32'(ram_m[PAGE_WORDS]));
    check("new_page", 32'(ps1), 32'd2);
    op(0, 0, 0, 0, 8'h00, 0, 8'h00);
    check("old_page_rd2", 32'(dout2), 32'(ram_m[PAGE_WORDS]));

    // Reset while a lat-2 read is in flight.
    op(1, 1, 0, 1, 8'h00, 0, 8'h00);
    do_reset();
    check("rst_no_valid", 32'(dv2), 32'd0);
    check("rst_dout", 32'(dout2), 32'd0);
    op(0, 0, 0, 0, 8'h00, 0, 8'h00);
    check("rst_no_late", 32'(dv2), 32'd0);

    // Lock bit, and memory surviving reset.
    op(0, 0, 0, 0, 8'h00, 1, 8'h25);
    check("lock_page", 32'(ps1), 32'd5);
    check("lock_bit", 32'(lk1), 32'd1);
    op(0, 0, 0, 0, 8'h00, 1, 8'h02);
    check("lock_hold", 32'(ps1), 32'd5);
    do_reset();
    check("unlock_page", 32'(ps1), 32'd0);
    check("unlock_bit", 32'(lk1), 32'd0);
    op(0, 0, 0, 0, 8'h00, 1, 8'h05);
    op(1, 1, 0, 2, 8'h00, 0, 8'h00);
    check("mem_kept", 32'(dout1), 32'(ram_m[5 * PAGE_WORDS + 2]));

    // Random traffic; the lock bit stays clear so paging keeps moving.
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, 4);
      op($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
         (a == 4) ? 16 : a, 8'($urandom), $urandom_range(0, 4) == 0,
         8'($urandom) & 8'hDF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
